// File: rtl/i2c_bus_conditioner.sv
// I2C open-drain bus resolution, synchronisation and glitch filtering, plus
// START/STOP/edge event detection, bus-busy tracking and per-agent arbitration loss.

module i2c_bus_conditioner_line #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic pclk,
    input  logic areset,
    input  logic raw,
    output logic filt,
    output logic filt_prev
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   prev_q, prev_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d  = '0;
        filt_d = filt_q;
        prev_d = filt_q;
        // A change is accepted only after FILTER_LEN consecutive differing cycles
        if (sync_out != filt_q) begin
            if (cnt_q == CNT_MAX) filt_d = sync_out;
            else                  cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            prev_q <= prev_d;
        end
    end

    assign filt      = filt_q;
    assign filt_prev = prev_q;
endmodule

module i2c_bus_conditioner #(
    parameter int NUM_AGENTS  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic [NUM_AGENTS-1:0] scl_o,
    input  logic [NUM_AGENTS-1:0] scl_oen,
    input  logic [NUM_AGENTS-1:0] sda_o,
    input  logic [NUM_AGENTS-1:0] sda_oen,
    input  logic                  scl_pad_i,
    input  logic                  sda_pad_i,
    output logic                  scl_pad_oe,
    output logic                  sda_pad_oe,
    output logic                  scl_i,
    output logic                  sda_i,
    output logic                  scl_rise,
    output logic                  scl_fall,
    output logic                  start_det,
    output logic                  rstart_det,
    output logic                  stop_det,
    output logic                  bus_busy,
    output logic [NUM_AGENTS-1:0] arb_lost
);
    typedef enum logic {IDLE, BUSY} state_t;

    logic [NUM_AGENTS-1:0] pull_scl, pull_sda;
    logic scl_raw, sda_raw, scl_f, scl_p, sda_f, sda_p;
    logic start_c, stop_c, rise_c, fall_c;
    state_t state_q, state_d;
    logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;

    assign pull_scl   = scl_oen & ~scl_o;
    assign pull_sda   = sda_oen & ~sda_o;
    assign scl_pad_oe = !areset && (|pull_scl);
    assign sda_pad_oe = !areset && (|pull_sda);
    // Local pulls are merged in directly so a lagging pad echo cannot hide them
    assign scl_raw    = scl_pad_i & ~(|pull_scl);
    assign sda_raw    = sda_pad_i & ~(|pull_sda);

    i2c_bus_conditioner_line #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .pclk(pclk), .areset(areset), .raw(scl_raw), .filt(scl_f), .filt_prev(scl_p)
    );
    i2c_bus_conditioner_line #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .pclk(pclk), .areset(areset), .raw(sda_raw), .filt(sda_f), .filt_prev(sda_p)
    );

    // SCL must be high in both cycles, so a simultaneous SCL edge suppresses START/STOP
    assign start_c = scl_f & scl_p &  sda_p & ~sda_f;
    assign stop_c  = scl_f & scl_p & ~sda_p &  sda_f;
    assign rise_c  =  scl_f & ~scl_p;
    assign fall_c  = ~scl_f &  scl_p;

    always_comb begin
        state_d    = state_q;
        scl_rise_d = rise_c;
        scl_fall_d = fall_c;
        start_d    = start_c;
        stop_d     = stop_c;
        rstart_d   = 1'b0;
        case (state_q)
            IDLE: if (start_c) state_d = BUSY;
            BUSY: begin
                rstart_d = start_c;
                if (stop_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            state_q    <= IDLE;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            rstart_q   <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            rstart_q   <= rstart_d;
            stop_q     <= stop_d;
        end
    end

    assign scl_i      = scl_f;
    assign sda_i      = sda_f;
    assign scl_rise   = scl_rise_q;
    assign scl_fall   = scl_fall_q;
    assign start_det  = start_q;
    assign rstart_det = rstart_q;
    assign stop_det   = stop_q;
    assign bus_busy   = (state_q == BUSY);
    // An agent releasing SDA high while the bus reads low at the SCL rise has lost
    assign arb_lost   = areset ? '0 :
                        ({NUM_AGENTS{scl_rise_q}} & sda_oen & sda_o & {NUM_AGENTS{~sda_f}});
endmodule
